// File: rtl/secp256k1_pkg.sv
// Shared constants and types for the secp256k1 field arithmetic blocks.
// p = 2^256 - 2^32 - 977; K = 2^256 mod p is the folding constant.
package secp256k1_pkg;

  localparam int FIELD_W = 256;
  localparam int ACC_W   = 290;
  localparam int PROD_W  = 520;
  localparam int SEG_W   = 16;
  localparam int SEG_N   = 16;
  localparam int K_W     = 33;

  localparam logic [FIELD_W-1:0] P_FIELD =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  localparam logic [K_W-1:0] K_FOLD = 33'h1_0000_03D1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FOLD1 = 3'd1,
    ST_FOLD2 = 3'd2,
    ST_SUB   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/secp256k1_cond_sub.sv
// Combinational compare-with-p and conditional subtract on a 257-bit value.
// Used once by the reducer and shared by both SUB cycles.
module secp256k1_cond_sub
  import secp256k1_pkg::*;
(
  input  logic [FIELD_W:0] a,
  output logic [FIELD_W:0] y
);

  logic [FIELD_W:0] p_ext;

  assign p_ext = {1'b0, P_FIELD};

  // Subtract p only when a >= p, otherwise pass a through unchanged.
  always_comb begin
    y = a;
    if (a >= p_ext) begin
      y = a - p_ext;
    end
  end

endmodule

// File: rtl/secp256k1_mod_reduce.sv
// Sequential reducer: 512-bit product mod p for secp256k1.
// Fixed 20-clock latency from the start-sampling edge to valid.
// Optional overflow flag on product[519:512] is enabled by defining
// SECP_MODRED_OVF_CHECK_EN; otherwise err is tied low.
//
// Handshake: start is a level request sampled only in IDLE and must be held
// until valid is seen, then dropped. valid stays high while in DONE and
// clears one edge after the block returns to IDLE. result holds from the
// load edge until the next capture.
module secp256k1_mod_reduce
  import secp256k1_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [519:0]      product,
  output logic              valid,
  output logic [255:0]      result,
  output logic              err,
  output logic [2:0]        fsm_state
);

  state_t             state;
  state_t             state_next;
  logic [FIELD_W-1:0] hi;
  logic [ACC_W-1:0]   acc;
  logic [3:0]         j;
  logic               sub_cnt;

  logic [SEG_W-1:0]   seg;
  logic [48:0]        seg_prod;
  logic [ACC_W-1:0]   fold1_term;
  logic [66:0]        fold2_prod;
  logic [FIELD_W:0]   fold2_sum;
  logic [FIELD_W:0]   sub_y;
  logic [7:0]         shamt;
  logic               capture;

  assign fsm_state = state;
  assign capture   = (state == ST_IDLE) && start;
  assign shamt     = {j, 4'b0000};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; unreachable encodings fall back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_FOLD1;
      ST_FOLD1: if (j == 4'(SEG_N - 1)) state_next = ST_FOLD2;
      ST_FOLD2: state_next = ST_SUB;
      ST_SUB:   if (sub_cnt) state_next = ST_DONE;
      ST_DONE:  if (!start) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Fold arithmetic: one 16x33 partial product per FOLD1 cycle, then the
  // 34x33 fold of the bits above 2^256.
  always_comb begin
    seg        = 16'(hi >> shamt);
    seg_prod   = 49'(seg) * 49'(K_FOLD);
    fold1_term = {{(ACC_W-49){1'b0}}, seg_prod} << shamt;
    fold2_prod = 67'(acc[ACC_W-1:FIELD_W]) * 67'(K_FOLD);
    fold2_sum  = {1'b0, acc[FIELD_W-1:0]} + {{(FIELD_W+1-67){1'b0}}, fold2_prod};
  end

  secp256k1_cond_sub u_cond_sub (
    .a (acc[FIELD_W:0]),
    .y (sub_y)
  );

  // Datapath registers: capture, fold, conditional subtract, result load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi      <= '0;
      acc     <= '0;
      j       <= '0;
      sub_cnt <= 1'b0;
      result  <= '0;
      valid   <= 1'b0;
    end else begin
      valid <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            hi      <= product[511:256];
            acc     <= {{(ACC_W-FIELD_W){1'b0}}, product[255:0]};
            j       <= '0;
            sub_cnt <= 1'b0;
          end
        end
        ST_FOLD1: begin
          acc <= acc + fold1_term;
          j   <= j + 4'd1;
        end
        ST_FOLD2: begin
          acc <= {{(ACC_W-FIELD_W-1){1'b0}}, fold2_sum};
        end
        ST_SUB: begin
          acc     <= {{(ACC_W-FIELD_W-1){1'b0}}, sub_y};
          sub_cnt <= ~sub_cnt;
          if (sub_cnt) begin
            result <= sub_y[FIELD_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SECP_MODRED_OVF_CHECK_EN
  // Overflow flag: sampled at capture, held until the next capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (capture) begin
      err <= |product[PROD_W-1:512];
    end
  end
`else
  logic ovf_unused;
  assign ovf_unused = capture | (|product[PROD_W-1:512]);
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_secp256k1_mod_reduce.sv
// Directed + random bench for secp256k1_mod_reduce with an expected-result queue.
module tb_secp256k1_mod_reduce;
  import secp256k1_pkg::*;

`ifdef SECP_MODRED_OVF_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [519:0] product;
  logic         valid;
  logic [255:0] result;
  logic         err;
  logic [2:0]   fsm_state;

  int vectors     = 0;
  int miscompares = 0;

  logic [255:0] exp_q[$];
  logic         exp_err_q[$];

  // Clock / reset block.
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  secp256k1_mod_reduce dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .product   (product),
    .valid     (valid),
    .result    (result),
    .err       (err),
    .fsm_state (fsm_state)
  );

  // Scoreboard compare.
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference model: plain wide modulo.
  function automatic logic [255:0] ref_mod(input logic [511:0] x);
    logic [511:0] r;
    r = x % {256'd0, P_FIELD};
    return r[255:0];
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  // Driver: one full reduction with latency, result, err and release checks.
  task automatic run_op(input string tag, input logic [519:0] prod_in,
                        input logic [255:0] exp_res, input int hold);
    logic [255:0] e;
    logic         ee;
    int           cnt;
    exp_q.push_back(exp_res);
    exp_err_q.push_back(OVF_EN & (|prod_in[519:512]));
    @(negedge clk);
    product = prod_in;
    start   = 1'b1;
    @(posedge clk);
    #1 product = ~prod_in;
    cnt = 0;
    while (cnt < 40) begin
      @(negedge clk);
      if (valid) break;
      @(posedge clk);
      cnt++;
    end
    check({tag, " latency"}, 256'(cnt), 256'd20);
    e  = exp_q.pop_front();
    ee = exp_err_q.pop_front();
    check({tag, " result"}, result, e);
    check({tag, " err"}, 256'(err), 256'(ee));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, " hold valid"}, 256'(valid), 256'd1);
      check({tag, " hold state"}, 256'(fsm_state), 256'(ST_DONE));
      check({tag, " hold result"}, result, e);
    end
    start = 1'b0;
    @(negedge clk);
    check({tag, " release valid1"}, 256'(valid), 256'd1);
    check({tag, " release state"}, 256'(fsm_state), 256'(ST_IDLE));
    @(negedge clk);
    check({tag, " release valid2"}, 256'(valid), 256'd0);
    check({tag, " release result"}, result, e);
  endtask

  initial begin
    logic [519:0] v;
    logic [511:0] pm1;
    logic [511:0] r;

    rst     = 1'b0;
    start   = 1'b0;
    product = '0;
    #1;
    check("reset valid", 256'(valid), 256'd0);
    check("reset result", result, 256'd0);
    check("reset err", 256'(err), 256'd0);
    check("reset state", 256'(fsm_state), 256'(ST_IDLE));
    repeat (3) @(negedge clk);
    rst = 1'b1;

    run_op("zero", 520'd0, 256'd0, 0);
    run_op("p", {264'd0, P_FIELD}, 256'd0, 0);
    v = 520'd1 << 256;
    run_op("two256", v, 256'h1_0000_03D1, 0);
    pm1 = {256'd0, P_FIELD} - 512'd1;
    v = {8'd0, pm1 * pm1};
    run_op("pm1sq", v, 256'd1, 0);
    v = {8'hFF, 512'd5};
    run_op("ovf", v, 256'd5, 0);
    v = {8'd0, {512{1'b1}}};
    run_op("allones", v, ref_mod(v[511:0]), 0);
    v = {264'd0, P_FIELD - 256'd1};
    run_op("pminus1", v, P_FIELD - 256'd1, 0);

    // Reset in the middle of FOLD1 aborts and clears outputs at once.
    @(negedge clk);
    product = {8'd0, rand512()};
    start   = 1'b1;
    @(posedge clk);
    repeat (8) @(posedge clk);
    #2;
    check("abort pre state", 256'(fsm_state), 256'(ST_FOLD1));
    rst = 1'b0;
    #1;
    check("abort valid", 256'(valid), 256'd0);
    check("abort result", result, 256'd0);
    check("abort err", 256'(err), 256'd0);
    check("abort state", 256'(fsm_state), 256'(ST_IDLE));
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    v = 520'd1 << 256;
    run_op("after abort", v, 256'h1_0000_03D1, 0);

    // start held past valid: no re-run, valid stays up.
    r = rand512();
    run_op("hold", {8'd0, r}, ref_mod(r), 10);

    for (int n = 0; n < 6; n++) begin
      r = rand512();
      run_op("random", {8'd0, r}, ref_mod(r), 0);
    end
    r = rand512();
    v = {8'h3C, r};
    run_op("random ovf", v, ref_mod(r), 0);

    check("queue empty", 256'(exp_q.size()), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/secp256k1_mod_reduce.md
# secp256k1_mod_reduce

Sequential modular reducer for the secp256k1 field, p = 2^256 − 2^32 − 977. It sits directly downstream of the 264×256 sequential multiplier. It consumes that multiplier's 520-bit product, of which the low 512 bits are significant, and returns the canonical 256-bit residue in [0, p). It uses the same start/valid handshake as the multiplier, so a point-arithmetic controller can chain multiply → reduce without glue logic.

## Interface
- No parameters. Field constants come from the shared package.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: level request. Sampled only in IDLE. Must be held until `valid` is seen, then dropped.
- `product` input 520: multiplier output. Bits [511:0] are the value. Bits [519:512] are expected to be zero.
- `valid` output 1: result ready. Stays high while the block is in DONE.
- `result` output 256: product mod p, canonical (< p). Registered.
- `err` output 1: `product[519:512]` was non-zero at capture. Tied 0 unless the macro is enabled.

## Operation
- Constant K = 2^256 mod p = 0x1000003D1 (33 bits).
- States: IDLE, FOLD1, FOLD2, SUB, DONE. Encodings come from the package.
- IDLE:
  - `valid` ← 0.
  - On `start`=1: latch hi ← product[511:256], acc (290 b) ← product[255:0], j ← 0, go to FOLD1.
- FOLD1:
  - Each cycle: acc ← acc + ((hi[16j+:16] × K) << 16j). The 16×33 product is 49 bits.
  - j increments 0..15. At j==15, go to FOLD2.
  - Result: acc < 2^290, with no overflow.
- FOLD2: one cycle.
  - acc ← acc[255:0] + acc[289:256] × K. This is a 34×33 multiply.
  - Result < 2^256 + 2^67 (fits 257 b).
- SUB: exactly 2 cycles, giving constant latency.
  - Each cycle: if acc ≥ p then acc ← acc − p, else hold.
  - Two conditional subtractions always suffice.
  - On the second cycle: result ← final acc[255:0], go to DONE.
- DONE:
  - `valid` ← 1.
  - If `start`=0, go to IDLE. `valid` clears on the following edge.
- `product` is captured only at IDLE→FOLD1. Upstream may change it afterwards.
- `start` high outside IDLE is ignored. There is no restart mid-operation.
- An unreachable state encoding returns to IDLE.

## Timing
- Reset (`rst`=0, asynchronous):
  - state=IDLE.
  - `valid`=0, `result`=0, `err`=0.
  - acc, hi and j are cleared.
- Reset asserted mid-operation aborts immediately. The next start begins a fresh reduction.
- Let E0 be the edge that samples `start`=1 in IDLE:
  - E1–E16: FOLD1.
  - E17: FOLD2.
  - E18–E19: SUB.
  - E19: `result` loaded, state=DONE.
  - E20: `valid`=1.
- Fixed latency is 20 clocks from the sampling edge to `valid` high, independent of data.
- `result` is stable from E19 until the next capture.
- If `start` is still high in DONE, the block stays in DONE with `valid`=1. It never re-triggers without `start` first returning low.
- Minimum turnaround: `start` low → IDLE → `valid`=0 → `start` sampled again. Back-to-back operations are therefore 22+ cycles apart.

## Configuration
- `SECP_MODRED_OVF_CHECK_EN` defined:
  - At capture, `err` ← |product[519:512].
  - `err` is held until the next capture or reset. The value is still reduced from bits [511:0].
- Not defined: `err` is constant 0 and the comparator is not synthesised.

## Structure
- The shared package `secp256k1_pkg` holds:
  - P_FIELD (256 b) and K_FOLD (33 b);
  - state enum/localparams;
  - width constants (ACC_W=290, PROD_W=520, SEG_W=16).
- One sub-module, `secp256k1_cond_sub`: combinational 257-bit compare-with-p and conditional subtract. It is instanced once and reused in both SUB cycles.

## Test plan
- product=0 → `result`=0, `valid` high exactly 20 clocks after the start-sampling edge.
- product=p → `result`=0.
- product=2^256 → `result`=0x1000003D1.
- product=(p−1)^2 → `result`=1.
- product with [519:512]=0xFF and [511:0]=5, macro enabled:
  - `result`=5, `err`=1.
  - Macro disabled: `err`=0.
- `rst` pulsed low at FOLD1 cycle 8 → outputs zero immediately, state IDLE. A new start with product=2^256 still yields 0x1000003D1.
- `start` held high 10 cycles past `valid` → `valid` stays 1 with no re-run. `start` dropped → `valid` falls 2 edges later.
